// File: rtl/pipeline_hazard_sequencer_if.sv
// Hazard-control bundle between hazard detection (master) and the pipeline sequencer (slave).
// HAZARD_PERF_COUNTERS_EN adds the 32-bit performance counter outputs.
interface pipeline_hazard_sequencer_if;
  logic load_use_stall;
  logic branch_taken_id;
  logic jump_id;
  logic md_start;
  logic md_is_div;
  logic pc_we;
  logic if_id_we;
  logic if_id_flush;
  logic id_ex_we;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic md_busy;
  logic md_done;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic [31:0] md_cycles;
`endif

  modport master (
    output load_use_stall, branch_taken_id, jump_id, md_start, md_is_div,
    input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush,
           md_busy, md_done
`ifdef HAZARD_PERF_COUNTERS_EN
    , input stall_cycles, flush_count, md_cycles
`endif
  );

  modport slave (
    input  load_use_stall, branch_taken_id, jump_id, md_start, md_is_div,
    output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush,
           md_busy, md_done
`ifdef HAZARD_PERF_COUNTERS_EN
    , output stall_cycles, flush_count, md_cycles
`endif
  );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Prioritised per-stage write-enables/flushes from load-use, redirect and MUL/DIV occupancy.
// Optional HAZARD_PERF_COUNTERS_EN adds stall/flush/md-occupancy counters.
module pipeline_hazard_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipeline_hazard_sequencer_if.slave    hz
);

  typedef enum logic {RUN, MD_BUSY} state_e;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pc_we_c, if_id_we_c, if_id_flush_c, id_ex_we_c;
  logic id_ex_flush_c, ex_mem_flush_c, md_busy_c, md_done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_we_c        = 1'b1;
    if_id_we_c     = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_we_c     = 1'b1;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    md_busy_c      = 1'b0;
    md_done_c      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.md_start) begin
          pc_we_c        = 1'b0;
          if_id_we_c     = 1'b0;
          id_ex_we_c     = 1'b0;
          ex_mem_flush_c = 1'b1;
          md_busy_c      = 1'b1;
          cnt_d          = hz.md_is_div ? DIV_LOAD : MUL_LOAD;
          state_d        = MD_BUSY;
        end else if (hz.load_use_stall) begin
          // Redirect in the same cycle is dropped; ID re-presents it once the load clears.
          pc_we_c       = 1'b0;
          if_id_we_c    = 1'b0;
          id_ex_flush_c = 1'b1;
        end else if (hz.branch_taken_id || hz.jump_id) begin
          if_id_flush_c = 1'b1;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          pc_we_c        = 1'b0;
          if_id_we_c     = 1'b0;
          id_ex_we_c     = 1'b0;
          ex_mem_flush_c = 1'b1;
          md_busy_c      = 1'b1;
          cnt_d          = cnt_q - 1'b1;
        end else begin
          md_done_c = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low for the whole time reset is held, not just at the edge.
  assign hz.pc_we        = rst_n & pc_we_c;
  assign hz.if_id_we     = rst_n & if_id_we_c;
  assign hz.if_id_flush  = rst_n & if_id_flush_c;
  assign hz.id_ex_we     = rst_n & id_ex_we_c;
  assign hz.id_ex_flush  = rst_n & id_ex_flush_c;
  assign hz.ex_mem_flush = rst_n & ex_mem_flush_c;
  assign hz.md_busy      = rst_n & md_busy_c;
  assign hz.md_done      = rst_n & md_done_c;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles_q, flush_count_q, md_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      md_cycles_q    <= '0;
    end else begin
      if (!pc_we_c)      stall_cycles_q <= stall_cycles_q + 32'd1;
      if (if_id_flush_c) flush_count_q  <= flush_count_q + 32'd1;
      if (md_busy_c)     md_cycles_q    <= md_cycles_q + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;
  assign hz.md_cycles    = md_cycles_q;
`endif

endmodule
